// File: rtl/fpga_pkg.sv
// Geometry constants, config field layout and routing index helpers for the 3x3 LUT fabric.
package fpga_pkg;

  localparam int unsigned N_ROWS     = 3;
  localparam int unsigned N_COLS     = 3;
  localparam int unsigned N_TRACKS   = 5;
  localparam int unsigned LUT_K      = 4;
  localparam int unsigned CB_FIELD_W = 7;
  localparam int unsigned SB_FIELD_W = 5;

  localparam int unsigned N_CLB     = N_ROWS * N_COLS;
  localparam int unsigned N_HSEG    = (N_ROWS - 1) * N_COLS;
  localparam int unsigned N_VSEG    = (N_COLS - 1) * N_ROWS;
  localparam int unsigned N_SEG     = N_HSEG + N_VSEG;
  localparam int unsigned N_SB      = (N_ROWS - 1) * (N_COLS - 1);
  localparam int unsigned SB_FIELDS = 12;
  localparam int unsigned LUT_W     = 1 << LUT_K;
  localparam int unsigned SRAM_W    = N_CLB * LUT_W;
  localparam int unsigned CB_W      = N_SEG * N_TRACKS * CB_FIELD_W;
  localparam int unsigned SB_W      = N_SB * SB_FIELDS * SB_FIELD_W;

  typedef enum logic [1:0] {SIDE_N, SIDE_E, SIDE_S, SIDE_W} side_e;
  typedef enum logic {SEG_H, SEG_V} seg_kind_e;

  // One connection-block field per segment track.
  typedef struct packed {
    logic             en;
    logic             drv_b;
    logic             in_b;
    logic [LUT_K-1:0] sel;
  } cb_field_t;

  function automatic int unsigned cb_off(int unsigned s, int unsigned k);
    return CB_FIELD_W * (N_TRACKS * s + k);
  endfunction

  function automatic int unsigned sb_off(int unsigned b, int unsigned f);
    return SB_FIELD_W * (SB_FIELDS * b + f);
  endfunction

  function automatic int unsigned seg_h(int unsigned j, int unsigned c);
    return j * N_COLS + c;
  endfunction

  function automatic int unsigned seg_v(int unsigned j, int unsigned r);
    return N_HSEG + j * N_ROWS + r;
  endfunction

  function automatic seg_kind_e seg_kind(int unsigned s);
    return (s < N_HSEG) ? SEG_H : SEG_V;
  endfunction

  // CLB index on the A side (above / left) of segment s.
  function automatic int unsigned seg_a(int unsigned s);
    int unsigned t;
    if (seg_kind(s) == SEG_H) return s;
    t = s - N_HSEG;
    return (t % N_ROWS) * N_COLS + t / N_ROWS;
  endfunction

  function automatic int unsigned seg_b(int unsigned s);
    if (seg_kind(s) == SEG_H) return s + N_COLS;
    return seg_a(s) + 1;
  endfunction

  // Segment attached to a given side of switch box b.
  function automatic int unsigned sb_seg(int unsigned b, side_e side);
    int unsigned j;
    int unsigned i;
    j = b / (N_COLS - 1);
    i = b % (N_COLS - 1);
    case (side)
      SIDE_N:  return seg_v(i, j);
      SIDE_S:  return seg_v(i, j + 1);
      SIDE_W:  return seg_h(j, i);
      default: return seg_h(j, i + 1);
    endcase
  endfunction

  // Fields run NE,NS,NW,EN,ES,EW,SN,SE,SW,WN,WE,WS: source is f/3, sink skips the source.
  function automatic side_e sb_from(int unsigned f);
    return side_e'(2'(f / 3));
  endfunction

  function automatic side_e sb_to(int unsigned f);
    int unsigned from;
    int unsigned m;
    from = f / 3;
    m    = f % 3;
    return side_e'(2'((m < from) ? m : m + 1));
  endfunction

endpackage

// File: rtl/fpga_clb.sv
// 4-input LUT logic cell; output is registered when FPGA_REG_OUT_EN is defined.
module fpga_clb
  import fpga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [LUT_W-1:0] tt,
  input  logic [LUT_K-1:0] lut_in,
  output logic             out
);

  logic lut;
  assign lut = tt[lut_in];

`ifdef FPGA_REG_OUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= 1'b0;
    else       out <= lut;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;
  assign out = lut;
`endif

endmodule

// File: rtl/fpga.sv
// 3x3 island fabric: CLBs, connection blocks and one-hop switch boxes, all config static.
// Define FPGA_REG_OUT_EN to register every CLB output.
module fpga
  import fpga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SRAM_W-1:0] sramConfig,
  input  logic [CB_W-1:0]   cbconfig,
  input  logic [SB_W-1:0]   sconfig,
  inout  wire  [LUT_K:0]    t01,
  inout  wire  [LUT_K:0]    t02,
  inout  wire  [LUT_K:0]    r01,
  inout  wire  [LUT_K:0]    r02,
  inout  wire  [LUT_K:0]    b01,
  inout  wire  [LUT_K:0]    b02,
  inout  wire  [LUT_K:0]    h01,
  inout  wire  [LUT_K:0]    h02
);

  localparam int unsigned N_IMP  = N_SB * SB_FIELDS;
  localparam int unsigned N_FEED = N_SEG * N_TRACKS;

  logic      [N_CLB-1:0][LUT_K-1:0]                 pad_in;
  logic      [N_CLB-1:0][LUT_K-1:0]                 clb_in;
  logic      [N_CLB-1:0]                            clb_out;
  cb_field_t [N_SEG-1:0][N_TRACKS-1:0]              cb;
  logic      [N_SB-1:0][SB_FIELDS-1:0][N_TRACKS-1:0] sb;
  logic      [N_SEG-1:0][N_TRACKS-1:0]              l_trk;
  logic      [N_SEG-1:0][N_TRACKS-1:0]              f_trk;
  logic      [N_SEG-1:0][N_TRACKS-1:0][N_IMP-1:0]   imp;
  logic      [N_CLB-1:0][LUT_K-1:0][N_FEED-1:0]     feed;

  // Pad groups around the perimeter; the centre CLB has none.
  assign pad_in[0] = t01[LUT_K-1:0];
  assign pad_in[1] = t02[LUT_K-1:0];
  assign pad_in[2] = r01[LUT_K-1:0];
  assign pad_in[5] = r02[LUT_K-1:0];
  assign pad_in[8] = b01[LUT_K-1:0];
  assign pad_in[7] = b02[LUT_K-1:0];
  assign pad_in[6] = h01[LUT_K-1:0];
  assign pad_in[3] = h02[LUT_K-1:0];
  assign pad_in[4] = '0;

  assign t01[LUT_K] = clb_out[0];
  assign t02[LUT_K] = clb_out[1];
  assign r01[LUT_K] = clb_out[2];
  assign r02[LUT_K] = clb_out[5];
  assign b01[LUT_K] = clb_out[8];
  assign b02[LUT_K] = clb_out[7];
  assign h01[LUT_K] = clb_out[6];
  assign h02[LUT_K] = clb_out[3];

  // Local track value: the single enabled CLB driver of each segment track.
  for (genvar s = 0; s < N_SEG; s++) begin : g_seg
    for (genvar k = 0; k < N_TRACKS; k++) begin : g_trk
      localparam int unsigned SA = seg_a(s);
      localparam int unsigned SB = seg_b(s);
      assign cb[s][k]    = cb_field_t'(cbconfig[cb_off(s, k) +: CB_FIELD_W]);
      assign l_trk[s][k] = cb[s][k].en & (cb[s][k].drv_b ? clb_out[SB] : clb_out[SA]);
    end
  end

  for (genvar b = 0; b < N_SB; b++) begin : g_sb_cfg
    for (genvar f = 0; f < SB_FIELDS; f++) begin : g_fld
      assign sb[b][f] = sconfig[sb_off(b, f) +: SB_FIELD_W];
    end
  end

  // Final track value: local drive OR switch-box imports of neighbours' local values (one hop).
  for (genvar s = 0; s < N_SEG; s++) begin : g_fin
    for (genvar k = 0; k < N_TRACKS; k++) begin : g_trk
      for (genvar b = 0; b < N_SB; b++) begin : g_box
        for (genvar f = 0; f < SB_FIELDS; f++) begin : g_fld
          localparam int unsigned FROM = sb_seg(b, sb_from(f));
          localparam bit          HIT  = (sb_seg(b, sb_to(f)) == s);
          assign imp[s][k][b*SB_FIELDS+f] = HIT & sb[b][f][k] & l_trk[FROM][k];
        end
      end
      assign f_trk[s][k] = l_trk[s][k] | (|imp[s][k]);
    end
  end

  // CLB inputs: pad bit OR every track selected onto that input from an adjacent segment.
  for (genvar i = 0; i < N_CLB; i++) begin : g_in
    for (genvar n = 0; n < LUT_K; n++) begin : g_pin
      for (genvar s = 0; s < N_SEG; s++) begin : g_seg
        for (genvar k = 0; k < N_TRACKS; k++) begin : g_trk
          localparam bit HIT_A = (seg_a(s) == i);
          localparam bit HIT_B = (seg_b(s) == i);
          assign feed[i][n][s*N_TRACKS+k] = f_trk[s][k] & cb[s][k].sel[n]
                                          & ((HIT_A & ~cb[s][k].in_b) | (HIT_B & cb[s][k].in_b));
        end
      end
      assign clb_in[i][n] = pad_in[i][n] | (|feed[i][n]);
    end
  end

  for (genvar i = 0; i < N_CLB; i++) begin : g_clb
    fpga_clb u_clb (
      .clk    (clk),
      .reset  (reset),
      .tt     (sramConfig[i*LUT_W +: LUT_W]),
      .lut_in (clb_in[i]),
      .out    (clb_out[i])
    );
  end

endmodule

// File: tb/tb_fpga.sv
// Directed bench for the fpga fabric: config table plus reset/latency sequences.
module tb_fpga;

  logic         clk;
  logic         reset;
  logic [143:0] sram;
  logic [419:0] cbc;
  logic [239:0] sbc;
  logic [31:0]  pad_drv;
  logic [7:0]   pad_out;
  wire  [4:0]   t01, t02, r01, r02, b01, b02, h01, h02;

  int checks;
  int failures;

  assign t01[3:0] = pad_drv[31:28];
  assign t02[3:0] = pad_drv[27:24];
  assign r01[3:0] = pad_drv[23:20];
  assign r02[3:0] = pad_drv[19:16];
  assign b01[3:0] = pad_drv[15:12];
  assign b02[3:0] = pad_drv[11:8];
  assign h01[3:0] = pad_drv[7:4];
  assign h02[3:0] = pad_drv[3:0];
  assign pad_out  = {t01[4], t02[4], r01[4], r02[4], b01[4], b02[4], h01[4], h02[4]};

  fpga dut (
    .clk        (clk),
    .reset      (reset),
    .sramConfig (sram),
    .cbconfig   (cbc),
    .sconfig    (sbc),
    .t01        (t01),
    .t02        (t02),
    .r01        (r01),
    .r02        (r02),
    .b01        (b01),
    .b02        (b02),
    .h01        (h01),
    .h02        (h02)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cfg;
    bit         rnd;
    logic [31:0] pads;
    logic [7:0]  exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s pad_bit4=%h expected=%h", name, got, exp);
    end
  endtask

  // 1: CLB(0,0) pass-through; 2: CLB(0,1) XOR4; 3: CB hop; 4: SB hop chain; 5: SB on wrong track.
  task automatic load_cfg(input int id);
    sram = '0;
    cbc  = '0;
    sbc  = '0;
    case (id)
      1: sram[15:0] = 16'hAAAA;
      2: sram[31:16] = 16'h6996;
      3: begin
        sram[15:0]  = 16'hAAAA;
        sram[63:48] = 16'hAAAA;
        cbc[6:0]    = 7'b1010001;
      end
      4, 5: begin
        sram[15:0]    = 16'hAAAA;
        sram[63:48]   = 16'hAAAA;
        sram[79:64]   = 16'hAAAA;
        cbc[20:14]    = 7'b1000000;
        cbc[55:49]    = 7'b0010001;
        cbc[258:252]  = 7'b1100001;
        if (id == 4) sbc[52] = 1'b1;
        else         sbc[51] = 1'b1;
      end
      default: ;
    endcase
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{0, 1'b1, 32'h0000_0000, 8'h00};
    vecs[1]  = '{0, 1'b1, 32'h0000_0000, 8'h00};
    vecs[2]  = '{0, 1'b1, 32'h0000_0000, 8'h00};
    vecs[3]  = '{1, 1'b0, 32'h1000_0000, 8'h80};
    vecs[4]  = '{1, 1'b0, 32'h0000_0000, 8'h00};
    vecs[5]  = '{1, 1'b0, 32'h1000_0000, 8'h80};
    vecs[6]  = '{1, 1'b0, 32'hE000_0000, 8'h00};
    vecs[7]  = '{2, 1'b0, 32'h0300_0000, 8'h00};
    vecs[8]  = '{2, 1'b0, 32'h0700_0000, 8'h40};
    vecs[9]  = '{2, 1'b0, 32'h0F00_0000, 8'h00};
    vecs[10] = '{2, 1'b0, 32'h0800_0000, 8'h40};
    vecs[11] = '{3, 1'b0, 32'h1000_0000, 8'h81};
    vecs[12] = '{3, 1'b0, 32'h0000_0000, 8'h00};
    vecs[13] = '{3, 1'b0, 32'h0000_0001, 8'h01};
    vecs[14] = '{3, 1'b0, 32'h00F0_0000, 8'h00};
    vecs[15] = '{4, 1'b0, 32'h1000_0000, 8'h81};
    vecs[16] = '{4, 1'b0, 32'h0000_0000, 8'h00};
    vecs[17] = '{4, 1'b0, 32'h0000_0001, 8'h01};
    vecs[18] = '{4, 1'b0, 32'hE000_0000, 8'h00};
    vecs[19] = '{5, 1'b0, 32'h1000_0000, 8'h80};

    reset   = 1'b1;
    pad_drv = '0;
    load_cfg(0);
    #3;
    check("reset_state", pad_out, 8'h00);

    // Pass-through configured while reset is held.
    load_cfg(1);
    pad_drv = 32'h1000_0000;
    repeat (2) @(posedge clk);
    #2;
`ifdef FPGA_REG_OUT_EN
    check("reset_hold", pad_out, 8'h00);
`else
    check("reset_hold", pad_out, 8'h80);
`endif
    reset = 1'b0;

    for (int v = 0; v < NV; v++) begin
      load_cfg(vecs[v].cfg);
      pad_drv = vecs[v].rnd ? $urandom : vecs[v].pads;
      repeat (3) @(posedge clk);
      #2;
      check($sformatf("vec%0d_cfg%0d", v, vecs[v].cfg), pad_out, vecs[v].exp);
    end

`ifdef FPGA_REG_OUT_EN
    load_cfg(1);
    pad_drv = '0;
    repeat (3) @(posedge clk);
    #2;
    pad_drv = 32'h1000_0000;
    #1;
    check("lat_before_edge", pad_out, 8'h00);
    @(posedge clk);
    #2;
    check("lat_after_edge", pad_out, 8'h80);
    reset = 1'b1;
    #1;
    check("async_reset", pad_out, 8'h00);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("reset_release", pad_out, 8'h80);
`else
    load_cfg(1);
    pad_drv = 32'h1000_0000;
    #1;
    check("comb_rise", pad_out, 8'h80);
    pad_drv = '0;
    #1;
    check("comb_fall", pad_out, 8'h00);
    reset   = 1'b1;
    pad_drv = 32'h1000_0000;
    #1;
    check("reset_no_effect", pad_out, 8'h80);
    reset = 1'b0;
    load_cfg(4);
    #1;
    check("comb_sb_chain", pad_out, 8'h81);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
